bus_source_ctrl: RTL and testbench

BUS_SOURCE_CTRL -- requirements
Module: bus_source_ctrl

---
 rtl/mini_src_pkg.sv | 41 ++++
 rtl/bus_source_ctrl_if.sv | 30 +++
 rtl/src_priority_enc.sv | 28 ++
 rtl/bus_source_ctrl.sv | 77 +++++++
 tb/tb_bus_source_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mini_src_pkg.sv
// Shared constants and types for the bus source selector: source indices,
// widths and the FSM state encoding.
package mini_src_pkg;

  localparam int unsigned W        = 32;
  localparam int unsigned NSRC_DEF = 24;
  localparam int unsigned CW_DEF   = 8;
  localparam int unsigned ENC_W    = 5;

  localparam int unsigned SRC_R0     = 0;
  localparam int unsigned SRC_R1     = 1;
  localparam int unsigned SRC_R2     = 2;
  localparam int unsigned SRC_R3     = 3;
  localparam int unsigned SRC_R4     = 4;
  localparam int unsigned SRC_R5     = 5;
  localparam int unsigned SRC_R6     = 6;
  localparam int unsigned SRC_R7     = 7;
  localparam int unsigned SRC_R8     = 8;
  localparam int unsigned SRC_R9     = 9;
  localparam int unsigned SRC_R10    = 10;
  localparam int unsigned SRC_R11    = 11;
  localparam int unsigned SRC_R12    = 12;
  localparam int unsigned SRC_R13    = 13;
  localparam int unsigned SRC_R14    = 14;
  localparam int unsigned SRC_R15    = 15;
  localparam int unsigned SRC_HI     = 16;
  localparam int unsigned SRC_LO     = 17;
  localparam int unsigned SRC_ZHIGH  = 18;
  localparam int unsigned SRC_ZLOW   = 19;
  localparam int unsigned SRC_PC     = 20;
  localparam int unsigned SRC_MDR    = 21;
  localparam int unsigned SRC_INPORT = 22;
  localparam int unsigned SRC_CSIGN  = 23;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRIVE    = 2'd1,
    ST_CONFLICT = 2'd2
  } state_e;

endpackage

// File: rtl/bus_source_ctrl_if.sv
// Bus-source request/data bundle; master drives requests and source values,
// slave (the selector) returns the registered bus and status.
interface bus_source_ctrl_if #(
  parameter int unsigned NSRC = mini_src_pkg::NSRC_DEF,
  parameter int unsigned W    = mini_src_pkg::W,
  parameter int unsigned CW   = mini_src_pkg::CW_DEF
);
  import mini_src_pkg::*;

  logic [NSRC-1:0]   out_req;
  logic [NSRC*W-1:0] src_data;
  logic              BAout;
  logic              stall;
  logic [W-1:0]      BusMuxOut;
  logic              bus_valid;
  logic [ENC_W-1:0]  enc_sel;
  logic              conflict;
  logic [CW-1:0]     conflict_count;

  modport master (
    output out_req, src_data, BAout, stall,
    input  BusMuxOut, bus_valid, enc_sel, conflict, conflict_count
  );

  modport slave (
    input  out_req, src_data, BAout, stall,
    output BusMuxOut, bus_valid, enc_sel, conflict, conflict_count
  );

endinterface

// File: rtl/src_priority_enc.sv
// Combinational lowest-index-wins encoder over the source request vector,
// plus any-request and multi-hot flags.
module src_priority_enc
  import mini_src_pkg::*;
#(
  parameter int unsigned NSRC = NSRC_DEF
) (
  input  logic [NSRC-1:0]  req,
  output logic [ENC_W-1:0] idx_c,
  output logic             any_c,
  output logic             multi_c
);

  // Descending scan so the lowest set bit is the last assignment
  always_comb begin
    idx_c = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (req[i]) idx_c = ENC_W'(i);
    end
  end

  // Clearing the lowest set bit leaves something only when two or more were set
  always_comb begin
    any_c   = |req;
    multi_c = |(req & (req - NSRC'(1)));
  end

endmodule

// File: rtl/bus_source_ctrl.sv
// Registered bus source selector: priority-picks one requester per cycle,
// tracks single/multi-hot requests in a small FSM and counts conflicts.
module bus_source_ctrl #(
  parameter int unsigned NSRC = mini_src_pkg::NSRC_DEF,
  parameter int unsigned W    = mini_src_pkg::W,
  parameter int unsigned CW   = mini_src_pkg::CW_DEF
) (
  input  logic             clk,
  input  logic             clr,
  bus_source_ctrl_if.slave bus
);
  import mini_src_pkg::*;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [ENC_W-1:0] win_idx_c;
  logic             any_c;
  logic             multi_c;
  logic [W-1:0]     win_data_c;
  logic [W-1:0]     bus_q;
  logic [ENC_W-1:0] sel_q;
  logic [CW-1:0]    cnt_q;

  src_priority_enc #(.NSRC(NSRC)) u_enc (
    .req     (bus.out_req),
    .idx_c   (win_idx_c),
    .any_c   (any_c),
    .multi_c (multi_c)
  );

  // Winner's data; R0 reads as zero during a base-address access
  always_comb begin
    win_data_c = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (win_idx_c == ENC_W'(i)) win_data_c = bus.src_data[i*W +: W];
    end
    if (win_idx_c == ENC_W'(SRC_R0) && bus.BAout) win_data_c = '0;
  end

  always_comb begin
    state_d = state_q;
    if (!bus.stall) begin
      if (multi_c)    state_d = ST_CONFLICT;
      else if (any_c) state_d = ST_DRIVE;
      else            state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Bus value and select hold when nothing requests; counter saturates
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bus_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
    end else if (!bus.stall) begin
      if (any_c) begin
        bus_q <= win_data_c;
        sel_q <= win_idx_c;
      end
      if (multi_c && cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
    end
  end

  // Valid and conflict are decodes of the state register, so they freeze with it
  assign bus.BusMuxOut      = bus_q;
  assign bus.enc_sel        = sel_q;
  assign bus.conflict_count = cnt_q;
  assign bus.bus_valid      = (state_q != ST_IDLE);
  assign bus.conflict       = (state_q == ST_CONFLICT);

endmodule

// File: tb/tb_bus_source_ctrl.sv
// Bench for bus_source_ctrl: directed vector table, multi-cycle corner
// sequences and randomized traffic against a behavioural model.
module tb_bus_source_ctrl;

  localparam int unsigned N    = 24;
  localparam int unsigned BW   = 32;
  localparam int unsigned CNTW = 8;
  localparam int          CMAX = (1 << CNTW) - 1;

  logic clk;
  logic clr;
  logic [BW-1:0] src [N];

  bus_source_ctrl_if #(.NSRC(N), .W(BW), .CW(CNTW)) bus ();

  bus_source_ctrl #(.NSRC(N), .W(BW), .CW(CNTW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.src_data[g*BW +: BW] = src[g];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected state of the outputs
  logic [BW-1:0] exp_bus;
  int            exp_sel;
  logic          exp_valid;
  logic          exp_conf;
  int            exp_cnt;
  int            tests;
  int            fails;

  typedef struct {
    logic [N-1:0]  req;
    logic          ba;
    logic          stl;
    logic [BW-1:0] e_bus;
    int            e_sel;
    logic          e_valid;
    logic          e_conf;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [BW-1:0] def_val(input int i);
    return {8'hC0, 8'(i), 16'h5A5A};
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string nm);
    cmp({nm, ".bus"},   64'(bus.BusMuxOut),      64'(exp_bus));
    cmp({nm, ".sel"},   64'(bus.enc_sel),        64'(exp_sel));
    cmp({nm, ".valid"}, 64'(bus.bus_valid),      64'(exp_valid));
    cmp({nm, ".conf"},  64'(bus.conflict),       64'(exp_conf));
    cmp({nm, ".cnt"},   64'(bus.conflict_count), 64'(exp_cnt));
  endtask

  task automatic model_reset();
    exp_bus   = '0;
    exp_sel   = 0;
    exp_valid = 1'b0;
    exp_conf  = 1'b0;
    exp_cnt   = 0;
  endtask

  // One rising edge as seen from the bus rules: lowest set bit wins
  task automatic model_edge();
    logic [N-1:0]  r;
    logic [N-1:0]  iso;
    int            pc;
    int            idx;
    logic [BW-1:0] d;
    if (bus.stall) return;
    r  = bus.out_req;
    pc = $countones(r);
    if (pc == 0) begin
      exp_valid = 1'b0;
      exp_conf  = 1'b0;
      return;
    end
    iso = r & (~r + N'(1));
    idx = 0;
    for (int i = 0; i < int'(N); i++) if (iso == (N'(1) << i)) idx = i;
    d = src[idx];
    if (idx == 0 && bus.BAout) d = '0;
    exp_bus   = d;
    exp_sel   = idx;
    exp_valid = 1'b1;
    exp_conf  = (pc > 1);
    if (pc > 1 && exp_cnt < CMAX) exp_cnt++;
  endtask

  task automatic tick(input string nm);
    @(posedge clk);
    if (clr) model_edge();
    #1;
    check_model(nm);
  endtask

  function automatic vec_t mk(input logic [N-1:0] req, input logic ba, input logic stl,
                              input logic [BW-1:0] eb, input int es, input logic ev,
                              input logic ec);
    vec_t v;
    v.req = req; v.ba = ba; v.stl = stl;
    v.e_bus = eb; v.e_sel = es; v.e_valid = ev; v.e_conf = ec;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_cnt;
    tests = 0;
    fails = 0;
    for (int i = 0; i < int'(N); i++) src[i] = def_val(i);
    src[0]  = 32'hDEAD_BEEF;
    src[5]  = 32'h1234_5678;
    src[20] = 32'h0000_0104;
    bus.out_req = '0;
    bus.BAout   = 1'b0;
    bus.stall   = 1'b0;
    clr = 1'b1;
    model_reset();
    #1 clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    clr = 1'b1;

    // Directed vectors, applied in order; each row's expectation follows the previous rows
    vecs[0]  = mk(N'(1) << 20,                 1'b0, 1'b0, 32'h0000_0104, 20, 1'b1, 1'b0);
    vecs[1]  = mk(N'(1),                       1'b1, 1'b0, 32'h0000_0000, 0,  1'b1, 1'b0);
    vecs[2]  = mk(N'(1),                       1'b0, 1'b0, 32'hDEAD_BEEF, 0,  1'b1, 1'b0);
    vecs[3]  = mk((N'(1) << 3) | (N'(1) << 19), 1'b0, 1'b0, 32'hC003_5A5A, 3,  1'b1, 1'b1);
    vecs[4]  = mk(N'(0),                       1'b0, 1'b0, 32'hC003_5A5A, 3,  1'b0, 1'b0);
    vecs[5]  = mk(N'(1) << 23,                 1'b0, 1'b0, 32'hC017_5A5A, 23, 1'b1, 1'b0);
    vecs[6]  = mk(24'hFF_FFFF,                 1'b1, 1'b0, 32'h0000_0000, 0,  1'b1, 1'b1);
    vecs[7]  = mk(24'hFF_FFFE,                 1'b1, 1'b0, 32'hC001_5A5A, 1,  1'b1, 1'b1);
    vecs[8]  = mk(N'(1) << 5,                  1'b0, 1'b1, 32'hC001_5A5A, 1,  1'b1, 1'b1);
    vecs[9]  = mk(N'(1) << 5,                  1'b0, 1'b0, 32'h1234_5678, 5,  1'b1, 1'b0);
    vecs[10] = mk(N'(1) << 22,                 1'b0, 1'b1, 32'h1234_5678, 5,  1'b1, 1'b0);
    vecs[11] = mk(N'(0),                       1'b0, 1'b0, 32'h1234_5678, 5,  1'b0, 1'b0);

    for (int v = 0; v < 12; v++) begin
      bus.out_req = vecs[v].req;
      bus.BAout   = vecs[v].ba;
      bus.stall   = vecs[v].stl;
      @(posedge clk);
      model_edge();
      #1;
      cmp($sformatf("vec%0d.bus", v),   64'(bus.BusMuxOut), 64'(vecs[v].e_bus));
      cmp($sformatf("vec%0d.sel", v),   64'(bus.enc_sel),   64'(vecs[v].e_sel));
      cmp($sformatf("vec%0d.valid", v), 64'(bus.bus_valid), 64'(vecs[v].e_valid));
      cmp($sformatf("vec%0d.conf", v),  64'(bus.conflict),  64'(vecs[v].e_conf));
      cmp($sformatf("vec%0d.cnt", v),   64'(bus.conflict_count), 64'(exp_cnt));
    end
    cmp("vec_conflicts", 64'(bus.conflict_count), 64'(3));
    bus.stall = 1'b0;
    bus.BAout = 1'b0;

    // R5 load then three idle cycles: value holds, valid drops
    bus.out_req = N'(1) << 5;
    tick("hold_load");
    bus.out_req = '0;
    for (int i = 0; i < 3; i++) begin
      tick($sformatf("hold_idle%0d", i));
      cmp($sformatf("hold_idle%0d.val", i), 64'(bus.BusMuxOut), 64'h1234_5678);
    end

    // Sustained conflict saturates the counter
    start_cnt = exp_cnt;
    bus.out_req = (N'(1) << 3) | (N'(1) << 19);
    tick("conf_first");
    cmp("conf_inc", 64'(bus.conflict_count), 64'(start_cnt + 1));
    for (int i = 0; i < 300; i++) tick("conf_hold");
    cmp("conf_sat", 64'(bus.conflict_count), 64'(CMAX));
    bus.out_req = '0;
    tick("conf_release");

    // Stall freezes everything while requests wander
    bus.out_req = N'(1) << 2;
    tick("stall_pre");
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.out_req = N'($urandom());
      bus.BAout   = 1'($urandom());
      tick("stall_frozen");
    end
    bus.stall   = 1'b0;
    bus.BAout   = 1'b0;
    bus.out_req = N'(1) << 7;
    tick("stall_release");
    cmp("stall_release.r7", 64'(bus.BusMuxOut), 64'(def_val(7)));

    // Asynchronous reset between edges during DRIVE
    bus.out_req = N'(1) << 9;
    tick("rst_pre");
    #2 clr = 1'b0;
    #1;
    model_reset();
    check_model("rst_async");
    #2 clr = 1'b1;
    bus.out_req = N'(1) << 21;
    tick("rst_mdr");
    cmp("rst_mdr.val", 64'(bus.BusMuxOut), 64'(def_val(21)));

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      case (mode)
        0:       bus.out_req = '0;
        1:       bus.out_req = N'(1) << $urandom_range(0, N - 1);
        2:       bus.out_req = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
        default: bus.out_req = N'($urandom());
      endcase
      bus.BAout = 1'($urandom());
      bus.stall = ($urandom_range(0, 7) == 0);
      src[$urandom_range(0, N - 1)] = $urandom();
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
